truth_table_sweeper: RTL and testbench

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/sweeper_pkg.sv | 9 +
 rtl/truth_table_sweeper_if.sv | 19 +
 rtl/hold_timer.sv | 16 +
 rtl/truth_table_sweeper.sv | 61 ++++++
 tb/tb_truth_table_sweeper.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sweeper_pkg.sv
// sweeper_pkg: state encoding and vector-count helper shared by the truth-table sweeper slice
package sweeper_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int nvec(input int n_in);
    return 1 << n_in;
  endfunction
endpackage

// File: rtl/truth_table_sweeper_if.sv
// truth_table_sweeper_if: sweep control, DUT stimulus/response and scoreboard results
interface truth_table_sweeper_if #(
  parameter int N_IN = 3,
  parameter int N_OUT = 1
);
  localparam int TW = N_OUT * sweeper_pkg::nvec(N_IN);
  logic start;
  logic abort;
  logic [N_OUT-1:0] y;
  logic [TW-1:0] exp_table;
  logic [N_IN-1:0] x;
  logic busy;
  logic done;
  logic [TW-1:0] table_out;
  logic [N_IN:0] mis_cnt;
  logic [N_IN-1:0] first_mis;
  modport master (output start, abort, y, exp_table, input x, busy, done, table_out, mis_cnt, first_mis);
  modport slave (input start, abort, y, exp_table, output x, busy, done, table_out, mis_cnt, first_mis);
endinterface

// File: rtl/hold_timer.sv
// hold_timer: counts HOLD cycles, flags the last one and restarts after it or while clr is high
module hold_timer #(
  parameter int HOLD = 20
) (
  input logic clk,
  input logic rst_n,
  input logic clr,
  output logic tc
);
  localparam int W = $clog2(HOLD);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(HOLD - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= clr || tc ? '0 : cnt + 1'b1;
endmodule

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps x through every input vector, captures y per vector and scores it against exp_table
module truth_table_sweeper
  import sweeper_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int N_OUT = 1,
  parameter int HOLD = 20
) (
  input logic clk,
  input logic rst_n,
  truth_table_sweeper_if.slave bus
);
  localparam int NVEC = nvec(N_IN);
  logic [1:0] state;
  logic tc;
  logic mis;
  assign mis = bus.y != bus.exp_table[int'(bus.x) * N_OUT +: N_OUT];
  hold_timer #(.HOLD(HOLD)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state != S_HOLD || bus.abort),
    .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      bus.x <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.table_out <= '0;
      bus.mis_cnt <= '0;
      bus.first_mis <= '0;
    end else if (state == S_IDLE) begin
      bus.done <= 1'b0;
      if (bus.start && !bus.abort) begin
        state <= S_HOLD;
        bus.x <= '0;
        bus.busy <= 1'b1;
        bus.table_out <= '0;
        bus.mis_cnt <= '0;
        bus.first_mis <= '0;
      end
    end else if (state == S_HOLD) begin
      if (bus.abort) begin
        state <= S_IDLE;
        bus.busy <= 1'b0;
      end else if (tc) begin
        bus.table_out[int'(bus.x) * N_OUT +: N_OUT] <= bus.y;
        if (mis) bus.mis_cnt <= bus.mis_cnt + 1'b1;
        if (mis && bus.mis_cnt == '0) bus.first_mis <= bus.x;
        if (bus.x == N_IN'(NVEC - 1)) begin
          state <= S_DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end else bus.x <= bus.x + 1'b1;
      end
    end else begin
      state <= S_IDLE;
      bus.done <= 1'b0;
    end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: directed and randomized sweeps of two sweeper configurations against a truth-table model
module tb_truth_table_sweeper;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  truth_table_sweeper_if #(.N_IN(3), .N_OUT(1)) ia ();
  truth_table_sweeper_if #(.N_IN(4), .N_OUT(2)) ib ();
  assign ia.y = ia.x[0] ^ ia.x[1] ^ ia.x[2];
  assign ib.y = {ib.x[3] & ib.x[2], ib.x[1] | ib.x[0]};
  truth_table_sweeper #(.N_IN(3), .N_OUT(1), .HOLD(20)) ua (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  truth_table_sweeper #(.N_IN(4), .N_OUT(2), .HOLD(2)) ub (.clk(clk), .rst_n(rst_n), .bus(ib.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Parity truth table over the first nsamp vectors, with mismatch count and lowest mismatch.
  function automatic logic [7:0] model_a(input logic [7:0] et, input int nsamp, output int mc, output int fm);
    logic [7:0] t;
    t = '0;
    mc = 0;
    fm = 0;
    for (int v = 0; v < nsamp; v++) begin
      t[v] = ($countones(v) % 2) == 1;
      if (t[v] != et[v]) begin
        if (mc == 0) fm = v;
        mc++;
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] model_b(input logic [31:0] et, output int mc, output int fm);
    logic [31:0] t;
    t = '0;
    mc = 0;
    fm = 0;
    for (int v = 0; v < 16; v++) begin
      t[2*v +: 2] = {v / 4 == 3, v % 4 != 0};
      if (t[2*v +: 2] != et[2*v +: 2]) begin
        if (mc == 0) fm = v;
        mc++;
      end
    end
    return t;
  endfunction

  task automatic reset_chk(input string tag);
    check({tag, "_a_x"}, ia.x, 0);
    check({tag, "_a_busy"}, ia.busy, 0);
    check({tag, "_a_done"}, ia.done, 0);
    check({tag, "_a_table"}, ia.table_out, 0);
    check({tag, "_a_mis"}, ia.mis_cnt, 0);
    check({tag, "_a_first"}, ia.first_mis, 0);
    check({tag, "_b_x"}, ib.x, 0);
    check({tag, "_b_busy"}, ib.busy, 0);
    check({tag, "_b_table"}, ib.table_out, 0);
    check({tag, "_b_mis"}, ib.mis_cnt, 0);
  endtask

  // ab = 0 runs a full sweep; otherwise abort is sampled on the ab-th edge after accept.
  task automatic run_a(input logic [7:0] et, input int ab);
    int mc, fm, lim, ns;
    logic [7:0] mt;
    logic seen;
    ia.exp_table = et;
    @(negedge clk) ia.start = 1'b1;
    @(negedge clk) ia.start = 1'b0;
    lim = ab > 0 ? ab : 160;
    for (int n = 0; n < lim; n++) begin
      check("a_busy", ia.busy, 1);
      check("a_done_low", ia.done, 0);
      check("a_x", ia.x, n / 20);
      if (n == ab - 1) ia.abort = 1'b1;
      @(negedge clk);
    end
    ia.abort = 1'b0;
    ns = ab > 0 ? (ab - 1) / 20 : 8;
    mt = model_a(et, ns, mc, fm);
    check("a_busy_end", ia.busy, 0);
    check("a_done_end", ia.done, ab == 0);
    check("a_x_end", ia.x, ab > 0 ? ns : 7);
    check("a_table", ia.table_out, mt);
    check("a_mis", ia.mis_cnt, mc);
    check("a_first", ia.first_mis, fm);
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      seen |= ia.done;
    end
    check("a_no_done_after", seen, 0);
    check("a_table_hold", ia.table_out, mt);
    check("a_mis_hold", ia.mis_cnt, mc);
  endtask

  task automatic run_b(input logic [31:0] et);
    int mc, fm;
    logic [31:0] mt;
    ib.exp_table = et;
    @(negedge clk) ib.start = 1'b1;
    @(negedge clk) ib.start = 1'b0;
    for (int n = 0; n < 32; n++) begin
      check("b_busy", ib.busy, 1);
      check("b_done_low", ib.done, 0);
      check("b_x", ib.x, n / 2);
      @(negedge clk);
    end
    mt = model_b(et, mc, fm);
    check("b_done", ib.done, 1);
    check("b_busy_end", ib.busy, 0);
    check("b_x_end", ib.x, 15);
    check("b_table", ib.table_out, mt);
    check("b_mis", ib.mis_cnt, mc);
    check("b_first", ib.first_mis, fm);
    @(negedge clk);
    check("b_done_pulse", ib.done, 0);
  endtask

  initial begin
    int ab;
    ia.start = 1'b0;
    ia.abort = 1'b0;
    ia.exp_table = '0;
    ib.start = 1'b0;
    ib.abort = 1'b0;
    ib.exp_table = '0;
    #12;
    reset_chk("rst");
    @(negedge clk) rst_n = 1'b1;
    run_a(8'h96, 0);
    run_a(8'h97, 0);
    run_a(8'h96, 50);
    @(negedge clk) begin
      ia.start = 1'b1;
      ia.abort = 1'b1;
    end
    @(negedge clk);
    check("prio_busy", ia.busy, 0);
    ia.start = 1'b0;
    ia.abort = 1'b0;
    ia.exp_table = 8'h96;
    @(negedge clk) ia.start = 1'b1;
    @(negedge clk);
    repeat (160) @(negedge clk);
    check("held_done1", ia.done, 1);
    @(negedge clk);
    check("held_idle_busy", ia.busy, 0);
    check("held_idle_done", ia.done, 0);
    @(negedge clk);
    check("held_reaccept_busy", ia.busy, 1);
    check("held_reaccept_x", ia.x, 0);
    repeat (160) @(negedge clk);
    check("held_done2", ia.done, 1);
    check("held_table", ia.table_out, 8'h96);
    ia.start = 1'b0;
    repeat (2) @(negedge clk);
    check("held_stop_busy", ia.busy, 0);
    for (int i = 0; i < 4; i++) begin
      ab = $urandom_range(0, 1) == 1 ? int'($urandom_range(1, 159)) : 0;
      run_a(8'($urandom), ab);
    end
    run_b(32'hFFFF_FFFF);
    run_b(32'hFA50_5554);
    for (int i = 0; i < 2; i++) run_b($urandom);
    ia.exp_table = 8'h97;
    ib.exp_table = 32'hFFFF_FFFF;
    @(negedge clk) begin
      ia.start = 1'b1;
      ib.start = 1'b1;
    end
    @(negedge clk) begin
      ia.start = 1'b0;
      ib.start = 1'b0;
    end
    repeat (25) @(negedge clk);
    check("pre_rst_a_mis", ia.mis_cnt, 1);
    check("pre_rst_b_busy", ib.busy, 1);
    #3 rst_n = 1'b0;
    #1;
    reset_chk("async");
    @(negedge clk) rst_n = 1'b1;
    run_a(8'($urandom), 0);
    run_b(32'hFFFF_FFFF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
